// File: rtl/sync_down_counter.sv
// Purpose: loadable WIDTH-bit down-counter/interval timer with one-shot and auto-reload modes.
// Latency: all outputs registered; load_val appears on q the edge after load=1, tc coincides with q==0.
// Backpressure: none; en stalls the count, load restarts it at any time.
//
// Ports:
//   clk      - system clock, all state changes on rising edge
//   rst      - asynchronous active-high reset
//   load     - load/restart strobe; wins over everything else on that edge
//   load_val - start/reload count, captured with load
//   mode     - 0 one-shot, 1 auto-reload, captured with load
//   en       - count enable
//   q        - current count
//   tc       - one-cycle terminal-count pulse, high in the cycle q reaches 0
//   busy     - high while counting (RUN)
//   done     - high after a one-shot expires (DONE) until the next load
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (load) begin
      // A terminal event coinciding with load is dropped: tc_d stays 0.
      reload_d = load_val;
      mode_d   = mode;
      count_d  = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              count_d = '0;
              tc_d    = 1'b1;
              if (!mode_q) state_d = DONE;
            end else begin
              // q==0 only happens in auto-reload: the extra cycle at zero
              // makes the period reload+1 and replaces the underflow wrap.
              count_d = reload_q;
            end
          end
        end
        DONE:    count_d = '0;
        default: ;
      endcase
    end

    // Status flags are registered from the next state so they never glitch.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sync_down_counter.sv
module tb_sync_down_counter;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         mode;
  logic         en;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;
  logic         done;

  int vectors    = 0;
  int miscompares = 0;
  int tc_count   = 0;
  logic prev_tc  = 1'b0;

  exp_t sb[$];

  // Reference model state
  logic [W-1:0] m_q, m_reload;
  logic         m_mode, m_tc;
  int           m_state;  // 0 idle, 1 run, 2 done

  sync_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .mode(mode),
    .en(en), .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_reload = '0; m_mode = 1'b0; m_tc = 1'b0; m_state = 0;
  endtask

  task automatic model_step(input logic ld, input logic [W-1:0] lv, input logic md, input logic e);
    m_tc = 1'b0;
    if (ld) begin
      m_reload = lv; m_mode = md; m_q = lv;
      m_state  = (lv != 0) ? 1 : 0;
    end else if (m_state == 1) begin
      if (e) begin
        if (m_q > 1) m_q = m_q - 1;
        else if (m_q == 1) begin
          m_q = '0; m_tc = 1'b1;
          if (!m_mode) m_state = 2;
        end else m_q = m_reload;
      end
    end else if (m_state == 2) begin
      m_q = '0;
    end
  endtask

  // One clock: drive on the falling edge, predict, then compare 1 time unit after the rising edge.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic md, input logic e);
    exp_t ex;
    @(negedge clk);
    load = ld; load_val = lv; mode = md; en = e;
    model_step(ld, lv, md, e);
    sb.push_back('{q: m_q, tc: m_tc, busy: (m_state == 1), done: (m_state == 2)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 16'(sb.size()), 16'd1);
    end else begin
      ex = sb.pop_front();
      check("q",    16'(q),    16'(ex.q));
      check("tc",   16'(tc),   16'(ex.tc));
      check("busy", 16'(busy), 16'(ex.busy));
      check("done", 16'(done), 16'(ex.done));
      check("tc_not_consecutive", 16'(prev_tc & tc), 16'd0);
      if (tc) begin
        tc_count++;
        check("tc_at_zero", 16'(q), 16'd0);
      end
      prev_tc = tc;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_q"},    16'(q),    16'd0);
    check({tag, "_tc"},   16'(tc),   16'd0);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_done"}, 16'(done), 16'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; mode = 1'b0; en = 1'b0;
    model_reset();
    #3;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: enable without load keeps everything idle
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("t1_tc_count", 16'(tc_count), 16'd0);

    // 2: one-shot from 5, then hold in DONE
    tc_count = 0;
    step(1'b1, 4'd5, 1'b0, 1'b1);
    check("t2_q_loaded", 16'(q), 16'd5);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("t2_tc_count", 16'(tc_count), 16'd1);
    check("t2_done_held", 16'(done), 16'd1);

    // 3: auto-reload from 3, period 4
    tc_count = 0;
    step(1'b1, 4'd3, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("t3_tc_count", 16'(tc_count), 16'd3);
    check("t3_busy", 16'(busy), 16'd1);

    // 4: one-shot from 6 with en toggling: tc on the 11th clock after load
    tc_count = 0;
    step(1'b1, 4'd6, 1'b0, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, '0, 1'b0, (i % 2) == 1);
      if (i == 10) check("t4_no_tc_yet", 16'(tc_count), 16'd0);
      if (i == 11) check("t4_tc_clock11", 16'(tc), 16'd1);
    end
    check("t4_tc_count", 16'(tc_count), 16'd1);

    // 5: reload at q==1 swallows tc, then async reset mid-count
    tc_count = 0;
    step(1'b1, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("t5_q_at_1", 16'(q), 16'd1);
    step(1'b1, 4'd9, 1'b0, 1'b1);
    check("t5_reload_q", 16'(q), 16'd9);
    check("t5_no_tc", 16'(tc_count), 16'd0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("t5_q_at_2", 16'(q), 16'd2);
    #2 rst = 1'b1;
    #1 check_cleared("async_rst");
    model_reset();
    prev_tc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

    // 6: maximum count in auto-reload, then load of zero
    tc_count = 0;
    step(1'b1, 4'd15, 1'b1, 1'b1);
    for (int i = 1; i <= 47; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (i == 14) check("t6_no_tc_before_15", 16'(tc_count), 16'd0);
      if (i == 15 || i == 31 || i == 47) check("t6_tc_on_period", 16'(tc), 16'd1);
    end
    check("t6_tc_count", 16'(tc_count), 16'd3);
    tc_count = 0;
    step(1'b1, 4'd0, 1'b1, 1'b1);
    check("t6_zero_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("t6_zero_tc_count", 16'(tc_count), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
Synchronous, loadable, parameterised down-counter/timer. It is the counting-down counterpart to the team's ripple up-counter.
- All flops sit on the single clk edge, with no derived clocks.
- Used as a programmable interval timer: load a count, decrement on enable, flag the terminal count.
- Two modes: one-shot, or auto-reload for periodic ticks.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  single-cycle load/restart strobe
load_val  input  WIDTH  start/reload count, sampled when load=1
mode  input  1  0 = one-shot, 1 = auto-reload; sampled when load=1
en  input  1  count enable; decrement only when 1
q  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse, registered, one cycle wide
busy  output  1  1 while in RUN
done  output  1  1 while in DONE (one-shot expired); cleared by load

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values, asserted immediately when rst=1 regardless of clk:
  - q=0, tc=0, busy=0, done=0
  - internal reload_reg=0, mode_reg=0, state=IDLE
- States: IDLE, RUN, DONE. busy and done are decoded registered from state, with no glitch path.
- load has priority over en, tc logic and state on the same edge:
  - reload_reg<=load_val, mode_reg<=mode, q<=load_val, done<=0, tc<=0
  - if load_val!=0, state<=RUN; else state<=IDLE
  - load during RUN restarts the count. A pending 1->0 terminal event in that same cycle is discarded: no tc.
- IDLE: q holds its value; en is ignored; tc=0.
- RUN, en=0: q holds; tc=0. No timeout.
- RUN, en=1, q>1: q<=q-1; tc=0.
- RUN, en=1, q==1:
  - q<=0, tc<=1 for exactly one cycle, coincident with q==0.
  - mode_reg=0: state<=DONE, so busy falls and done rises in the same cycle as tc.
  - mode_reg=1: stay in RUN.
- RUN, en=1, q==0 (reachable only with mode_reg=1): q<=reload_reg; tc=0.
  - Auto-reload period is (reload_reg+1) enabled cycles.
  - Exactly one tc is produced per period.
- DONE: q holds 0; en is ignored; tc=0. Only load or rst exits.
- Arithmetic:
  - Unsigned, WIDTH bits. The decrement never wraps below 0; wrap is replaced by reload or DONE.
  - load_val = 2^WIDTH-1 is legal (maximum count).
- load_val=1: the first enabled cycle produces tc, giving the shortest interval.
- Reset mid-count: everything returns to reset values at once. The counter stays in IDLE until a new load.
- tc must never be asserted two consecutive cycles. en stuck at 1 in auto-reload with reload_reg=1 gives tc on every 2nd cycle.

Test Plan:
1. Reset and release, then pulse en for 5 cycles without a load -> q=0, tc=0, busy=0, done=0 throughout.
2. load_val=5, mode=0, en held at 1 -> q goes 5,4,3,2,1,0. tc=1 only in the cycle q=0. busy drops and done rises in that cycle. q stays 0 and done stays 1 for 10 further cycles.
3. load_val=3, mode=1, en=1 for 12 cycles -> q goes 3,2,1,0,3,2,1,0,3,... with tc on each q=0 cycle, i.e. every 4 cycles; busy stays 1.
4. load_val=6, mode=0; en toggles 1,0,1,0... -> q decrements only on en=1 cycles. tc appears after 6 enabled cycles (11 clocks).
5. load_val=4 running; at q=1 with en=1, assert load with load_val=9 -> next q=9, no tc pulse, busy=1. Then q=2 with en=1, rst pulsed asynchronously mid-cycle -> outputs clear before the next edge and the counter stays in IDLE.
6. WIDTH=4, load_val=15, mode=1 -> first tc after 15 enabled cycles, then one tc every 16 cycles. Also load_val=0 -> state IDLE, busy=0, no tc ever.
